// File: rtl/sysid_read_arbiter.sv
// Two-master round-robin read arbiter in front of the single-port sysid slave.
// Each master gets a pipelined Avalon-MM read port with waitrequest and fixed-latency readdatavalid.

module sysid_read_arbiter #(
   parameter int ADDR_W = 1,
   parameter int DATA_W = 32
) (
   input  logic              clock,
   input  logic              reset_n,

   input  logic [ADDR_W-1:0] m0_address,
   input  logic              m0_read,
   output logic              m0_waitrequest,
   output logic [DATA_W-1:0] m0_readdata,
   output logic              m0_readdatavalid,

   input  logic [ADDR_W-1:0] m1_address,
   input  logic              m1_read,
   output logic              m1_waitrequest,
   output logic [DATA_W-1:0] m1_readdata,
   output logic              m1_readdatavalid,

   output logic [ADDR_W-1:0] slv_address,
   input  logic [DATA_W-1:0] slv_readdata
);

   typedef enum logic {
      IDLE  = 1'b0,
      SERVE = 1'b1
   } state_t;

   state_t state;
   state_t state_next;
   logic   grant;
   logic   grant_next;
   logic   last_grant;
   logic   load_addr;
   logic   other_read;

   // From SERVE only the other master is considered, so a master that keeps
   // reading can never lock out its peer.
   assign other_read = grant ? m0_read : m1_read;

   always_comb begin
      state_next = state;
      grant_next = grant;
      load_addr  = 1'b0;
      case (state)
         IDLE: begin
            if (m0_read && m1_read) begin
               state_next = SERVE;
               grant_next = ~last_grant;
               load_addr  = 1'b1;
            end else if (m0_read) begin
               state_next = SERVE;
               grant_next = 1'b0;
               load_addr  = 1'b1;
            end else if (m1_read) begin
               state_next = SERVE;
               grant_next = 1'b1;
               load_addr  = 1'b1;
            end
         end
         SERVE: begin
            if (other_read) begin
               state_next = SERVE;
               grant_next = ~grant;
               load_addr  = 1'b1;
            end else begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state            <= IDLE;
         grant            <= 1'b0;
         last_grant       <= 1'b1;
         slv_address      <= '0;
         m0_readdata      <= '0;
         m0_readdatavalid <= 1'b0;
         m1_readdata      <= '0;
         m1_readdatavalid <= 1'b0;
      end else begin
         state            <= state_next;
         grant            <= grant_next;
         m0_readdatavalid <= 1'b0;
         m1_readdatavalid <= 1'b0;
         if (load_addr) begin
            slv_address <= grant_next ? m1_address : m0_address;
         end
         // The slave is combinational, so the word is captured on the same
         // edge that ends the SERVE cycle.
         if (state == SERVE) begin
            last_grant <= grant;
            if (grant) begin
               m1_readdata      <= slv_readdata;
               m1_readdatavalid <= 1'b1;
            end else begin
               m0_readdata      <= slv_readdata;
               m0_readdatavalid <= 1'b1;
            end
         end
      end
   end

   assign m0_waitrequest = m0_read && !((state == SERVE) && (grant == 1'b0));
   assign m1_waitrequest = m1_read && !((state == SERVE) && (grant == 1'b1));

endmodule

// File: tb/tb_sysid_read_arbiter.sv
// Testbench for sysid_read_arbiter: directed vector table, an alternation sequence,
// and randomized traffic checked against a served-master reference model.

module tb_sysid_read_arbiter;

   localparam int          ADDR_W  = 1;
   localparam int          DATA_W  = 32;
   localparam logic [31:0] ID_WORD = 32'h5A5A1234;

   logic              clock = 1'b0;
   logic              reset_n;
   logic [ADDR_W-1:0] m0_address;
   logic              m0_read;
   logic              m0_waitrequest;
   logic [DATA_W-1:0] m0_readdata;
   logic              m0_readdatavalid;
   logic [ADDR_W-1:0] m1_address;
   logic              m1_read;
   logic              m1_waitrequest;
   logic [DATA_W-1:0] m1_readdata;
   logic              m1_readdatavalid;
   logic [ADDR_W-1:0] slv_address;
   logic [DATA_W-1:0] slv_readdata;

   int errors = 0;
   int checks = 0;

   sysid_read_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clock            (clock),
      .reset_n          (reset_n),
      .m0_address       (m0_address),
      .m0_read          (m0_read),
      .m0_waitrequest   (m0_waitrequest),
      .m0_readdata      (m0_readdata),
      .m0_readdatavalid (m0_readdatavalid),
      .m1_address       (m1_address),
      .m1_read          (m1_read),
      .m1_waitrequest   (m1_waitrequest),
      .m1_readdata      (m1_readdata),
      .m1_readdatavalid (m1_readdatavalid),
      .slv_address      (slv_address),
      .slv_readdata     (slv_readdata)
   );

   // Sysid slave: two fixed words, combinational from the address.
   assign slv_readdata = (slv_address == 1'b1) ? ID_WORD : 32'h0;

   always #5 clock = ~clock;

   typedef struct {
      logic        rst_n;
      logic        r0;
      logic        a0;
      logic        r1;
      logic        a1;
      logic        exp_wr0;
      logic        exp_wr1;
      logic        exp_v0;
      logic [31:0] exp_d0;
      logic        exp_v1;
      logic [31:0] exp_d1;
      logic        exp_slv;
   } vec_t;

   vec_t vectors[$];

   function automatic vec_t mk(input logic rst_n, input logic r0, input logic a0,
                               input logic r1, input logic a1,
                               input logic wr0, input logic wr1,
                               input logic v0, input logic [31:0] d0,
                               input logic v1, input logic [31:0] d1,
                               input logic slv);
      vec_t v;
      v.rst_n = rst_n; v.r0 = r0; v.a0 = a0; v.r1 = r1; v.a1 = a1;
      v.exp_wr0 = wr0; v.exp_wr1 = wr1; v.exp_v0 = v0; v.exp_d0 = d0;
      v.exp_v1 = v1; v.exp_d1 = d1; v.exp_slv = slv;
      return v;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, actual, expected, $time);
      end
   endtask

   task automatic applyStimulus(input vec_t v);
      reset_n    = v.rst_n;
      m0_read    = v.r0;
      m0_address = v.a0;
      m1_read    = v.r1;
      m1_address = v.a1;
   endtask

   task automatic checkRow(input vec_t v, input int idx);
      checkOutput($sformatf("row%0d m0_waitrequest", idx), 32'(m0_waitrequest), 32'(v.exp_wr0));
      checkOutput($sformatf("row%0d m1_waitrequest", idx), 32'(m1_waitrequest), 32'(v.exp_wr1));
      checkOutput($sformatf("row%0d m0_readdatavalid", idx), 32'(m0_readdatavalid), 32'(v.exp_v0));
      checkOutput($sformatf("row%0d m0_readdata", idx), m0_readdata, v.exp_d0);
      checkOutput($sformatf("row%0d m1_readdatavalid", idx), 32'(m1_readdatavalid), 32'(v.exp_v1));
      checkOutput($sformatf("row%0d m1_readdata", idx), m1_readdata, v.exp_d1);
      checkOutput($sformatf("row%0d slv_address", idx), 32'(slv_address), 32'(v.exp_slv));
   endtask

   task automatic doReset();
      reset_n = 1'b0;
      m0_read = 1'b0; m0_address = '0;
      m1_read = 1'b0; m1_address = '0;
      @(posedge clock);
      @(posedge clock);
      #1;
      reset_n = 1'b1;
   endtask

   // Reference model: tracks which master (or none, -1) is served in the
   // current cycle and derives every output from that.
   int          model_srv;
   logic        model_last;
   logic        model_slv;
   logic        model_v[2];
   logic [31:0] model_d[2];

   function automatic logic [31:0] slave_word(input logic addr);
      return addr ? ID_WORD : 32'h0;
   endfunction

   task automatic modelReset();
      model_srv  = -1;
      model_last = 1'b1;
      model_slv  = 1'b0;
      model_v[0] = 1'b0; model_v[1] = 1'b0;
      model_d[0] = 32'h0; model_d[1] = 32'h0;
   endtask

   task automatic modelEdge();
      int nxt;
      int other;
      if (!reset_n) begin
         modelReset();
         return;
      end
      if (model_srv == -1) begin
         if (m0_read && m1_read) nxt = model_last ? 0 : 1;
         else if (m0_read)       nxt = 0;
         else if (m1_read)       nxt = 1;
         else                    nxt = -1;
      end else begin
         other = 1 - model_srv;
         nxt   = ((other == 0) ? m0_read : m1_read) ? other : -1;
      end
      model_v[0] = 1'b0;
      model_v[1] = 1'b0;
      if (model_srv != -1) begin
         model_d[model_srv] = slave_word(model_slv);
         model_v[model_srv] = 1'b1;
         model_last         = (model_srv == 1);
      end
      if (nxt != -1) model_slv = (nxt == 0) ? m0_address : m1_address;
      model_srv = nxt;
   endtask

   initial begin
      int cnt0;
      int cnt1;
      int strobes0;
      int strobes1;
      logic wr0_s;
      logic wr1_s;

      // Directed vectors: one row per cycle, inputs driven after the edge,
      // outputs checked on the falling edge.
      vectors.push_back(mk(1,1,1,0,0, 1,0, 0,32'h0,       0,32'h0,       0));
      vectors.push_back(mk(1,1,1,0,0, 0,0, 0,32'h0,       0,32'h0,       1));
      vectors.push_back(mk(1,0,0,0,0, 0,0, 1,ID_WORD,     0,32'h0,       1));
      vectors.push_back(mk(1,0,0,0,0, 0,0, 0,ID_WORD,     0,32'h0,       1));
      vectors.push_back(mk(0,0,0,0,0, 0,0, 0,ID_WORD,     0,32'h0,       1));
      vectors.push_back(mk(1,1,0,1,1, 1,1, 0,32'h0,       0,32'h0,       0));
      vectors.push_back(mk(1,1,0,1,1, 0,1, 0,32'h0,       0,32'h0,       0));
      vectors.push_back(mk(1,0,0,1,1, 0,0, 1,32'h0,       0,32'h0,       1));
      vectors.push_back(mk(1,0,0,0,0, 0,0, 0,32'h0,       1,ID_WORD,     1));
      vectors.push_back(mk(1,0,0,1,1, 0,1, 0,32'h0,       0,ID_WORD,     1));
      vectors.push_back(mk(1,0,0,1,1, 0,0, 0,32'h0,       0,ID_WORD,     1));
      vectors.push_back(mk(1,0,0,1,0, 0,1, 0,32'h0,       1,ID_WORD,     1));
      vectors.push_back(mk(1,0,0,1,0, 0,0, 0,32'h0,       0,ID_WORD,     0));
      vectors.push_back(mk(1,0,0,1,1, 0,1, 0,32'h0,       1,32'h0,       0));
      vectors.push_back(mk(1,0,0,1,1, 0,0, 0,32'h0,       0,32'h0,       1));
      vectors.push_back(mk(1,0,0,0,0, 0,0, 0,32'h0,       1,ID_WORD,     1));
      vectors.push_back(mk(1,0,0,1,1, 0,1, 0,32'h0,       0,ID_WORD,     1));
      vectors.push_back(mk(0,0,0,1,1, 0,0, 0,32'h0,       0,ID_WORD,     1));
      vectors.push_back(mk(1,0,0,1,1, 0,1, 0,32'h0,       0,32'h0,       0));
      vectors.push_back(mk(1,0,0,1,1, 0,0, 0,32'h0,       0,32'h0,       1));
      vectors.push_back(mk(1,0,0,0,0, 0,0, 0,32'h0,       1,ID_WORD,     1));
      vectors.push_back(mk(1,0,0,0,0, 0,0, 0,32'h0,       0,ID_WORD,     1));
      vectors.push_back(mk(1,0,1,0,1, 0,0, 0,32'h0,       0,ID_WORD,     1));
      vectors.push_back(mk(1,0,0,0,1, 0,0, 0,32'h0,       0,ID_WORD,     1));
      vectors.push_back(mk(1,0,1,0,0, 0,0, 0,32'h0,       0,ID_WORD,     1));

      $display("[TB] directed vector table");
      doReset();
      for (int i = 0; i < vectors.size(); i++) begin
         applyStimulus(vectors[i]);
         @(negedge clock);
         checkRow(vectors[i], i);
         @(posedge clock);
         #1;
      end

      // Both masters read continuously: grants must alternate with no bubble.
      $display("[TB] continuous alternation");
      doReset();
      m0_read = 1'b1; m0_address = 1'b1;
      m1_read = 1'b1; m1_address = 1'b0;
      @(posedge clock);
      #1;
      cnt0 = 0; cnt1 = 0; strobes0 = 0; strobes1 = 0;
      for (int i = 0; i < 9; i++) begin
         @(negedge clock);
         checkOutput($sformatf("alt%0d m0_waitrequest", i), 32'(m0_waitrequest),
                     32'(m0_read && (i % 2 != 0)));
         checkOutput($sformatf("alt%0d m1_waitrequest", i), 32'(m1_waitrequest),
                     32'(m1_read && (i % 2 == 0)));
         checkOutput($sformatf("alt%0d m0_readdatavalid", i), 32'(m0_readdatavalid),
                     32'((i >= 1) && ((i - 1) % 2 == 0)));
         checkOutput($sformatf("alt%0d m1_readdatavalid", i), 32'(m1_readdatavalid),
                     32'((i >= 1) && ((i - 1) % 2 == 1)));
         if (m0_readdatavalid) begin
            strobes0++;
            checkOutput($sformatf("alt%0d m0_readdata", i), m0_readdata, ID_WORD);
         end
         if (m1_readdatavalid) begin
            strobes1++;
            checkOutput($sformatf("alt%0d m1_readdata", i), m1_readdata, 32'h0);
         end
         @(posedge clock);
         #1;
         if (i < 8) begin
            if (i % 2 == 0) begin
               cnt0++;
               if (cnt0 == 4) m0_read = 1'b0;
            end else begin
               cnt1++;
               if (cnt1 == 4) m1_read = 1'b0;
            end
         end
      end
      checkOutput("alt m0 strobe count", 32'(strobes0), 32'd4);
      checkOutput("alt m1 strobe count", 32'(strobes1), 32'd4);

      // Randomized traffic with occasional resets against the model.
      $display("[TB] randomized traffic");
      doReset();
      modelReset();
      for (int c = 0; c < 3000; c++) begin
         @(negedge clock);
         checkOutput("rnd m0_waitrequest", 32'(m0_waitrequest), 32'(m0_read && (model_srv != 0)));
         checkOutput("rnd m1_waitrequest", 32'(m1_waitrequest), 32'(m1_read && (model_srv != 1)));
         checkOutput("rnd m0_readdatavalid", 32'(m0_readdatavalid), 32'(model_v[0]));
         checkOutput("rnd m0_readdata", m0_readdata, model_d[0]);
         checkOutput("rnd m1_readdatavalid", 32'(m1_readdatavalid), 32'(model_v[1]));
         checkOutput("rnd m1_readdata", m1_readdata, model_d[1]);
         checkOutput("rnd slv_address", 32'(slv_address), 32'(model_slv));
         wr0_s = m0_waitrequest;
         wr1_s = m1_waitrequest;
         @(posedge clock);
         modelEdge();
         #1;
         reset_n = ($urandom_range(0, 49) != 0);
         if (!m0_read || !wr0_s) begin
            m0_read    = ($urandom_range(0, 99) < 60);
            m0_address = 1'($urandom_range(0, 1));
         end
         if (!m1_read || !wr1_s) begin
            m1_read    = ($urandom_range(0, 99) < 60);
            m1_address = 1'($urandom_range(0, 1));
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/sysid_read_arbiter.md
Name: sysid_read_arbiter

Overview:
- Two-master round-robin read arbiter for the system-ID Avalon-MM slave: 1-bit address, read-only, combinational readdata, no waitrequest.
- Lets the Nios II data master (m0) and the JTAG/debug bridge master (m1) share the single sysid slave port without an interconnect-generated arbiter.
- Each master sees an Avalon-MM pipelined read interface with waitrequest and fixed-latency readdatavalid.

Parameters:
ADDR_W, 1, slave/master address width (word addresses)
DATA_W, 32, readdata width

Ports:
clock  in  1  system clock; all logic rising-edge
reset_n  in  1  synchronous, active-low reset
m0_address  in  ADDR_W  master 0 read address
m0_read  in  1  master 0 read request, held until waitrequest low
m0_waitrequest  out  1  master 0 stall
m0_readdata  out  DATA_W  master 0 read data
m0_readdatavalid  out  1  master 0 data strobe
m1_address  in  ADDR_W  master 1 read address
m1_read  in  1  master 1 read request
m1_waitrequest  out  1  master 1 stall
m1_readdata  out  DATA_W  master 1 read data
m1_readdatavalid  out  1  master 1 data strobe
slv_address  out  ADDR_W  address to sysid slave
slv_readdata  in  DATA_W  sysid slave data, combinational from slv_address

Behaviour:
- One clock (clock). Reset is synchronous, active-low (reset_n); sampled only on the rising edge.
- State machine: IDLE, SERVE. Registers: grant (0/1), last_grant, slv_address.
- Reset values: state=IDLE, grant=0, last_grant=1, slv_address=0, m0/m1_readdata=0, m0/m1_readdatavalid=0.
- IDLE edge:
  - no read -> stay IDLE.
  - only mX_read -> SERVE, grant=X.
  - both -> grant = ~last_grant.
  - On entering SERVE, slv_address <= m[grant]_address.
- SERVE cycle:
  - m[grant]_waitrequest=0. The transfer is accepted at the end of the cycle.
  - At that edge, m[grant]_readdata <= slv_readdata, m[grant]_readdatavalid <= 1 for exactly one cycle, last_grant <= grant.
- SERVE next state:
  - If the other master's read is asserted -> SERVE, grant flipped, slv_address <= its address (back-to-back, no bubble).
  - Else -> IDLE.
  - The just-served master's still-asserted read is not re-arbitrated at this edge. It is seen again from IDLE, or after the other master is served.
- waitrequest (combinational): mX_waitrequest = mX_read AND NOT(state==SERVE AND grant==X). It is 0 when mX_read=0.
- Latency:
  - read asserted at edge k (IDLE) -> waitrequest low during cycle k+1 -> readdatavalid high during cycle k+2.
  - Peak throughput is one read per cycle, alternating masters.
- readdata holds its last value between strobes. It is only meaningful while readdatavalid=1.
- Address changes by a master while waitrequest is high are not allowed (Avalon rule). The arbiter captures the address only when entering SERVE.
- Reset mid-operation (reset_n=0 in SERVE): the transfer is dropped with no readdatavalid, and all registers take their reset values. A master still holding read sees waitrequest=1 until re-served after reset release; m0 wins first contention.
- Starvation bound: a continuously requesting master waits at most one foreign transfer.

Test Plan:
- Slave model: addr0 -> 0x00000000, addr1 -> 0x5A5A1234. Single m0 read addr1 after reset -> m0_waitrequest low exactly 1 cycle; 2 cycles after request, m0_readdatavalid=1 for 1 cycle with m0_readdata=0x5A5A1234; m1 outputs stay 0.
- m0 (addr0) and m1 (addr1) assert read on the same edge after reset -> m0 served first; m1 served the next cycle; m0 gets 0x00000000 at cycle 2, m1 gets 0x5A5A1234 at cycle 3.
- Both masters hold read continuously for 8 transfers -> grants alternate m0, m1, m0…; 4 readdatavalid strobes each on consecutive cycles; no idle cycle once started.
- m1 alone issues 3 reads back-to-back -> each served via SERVE→IDLE→SERVE; readdatavalid at cycles 2, 4, 6.
- reset_n=0 for 1 cycle while in SERVE for m1 -> no m1_readdatavalid; outputs at reset values; m1 still reading is re-served 2 cycles after release with correct data.
- Idle bus with mX_read=0 and address toggling -> waitrequest=0, readdatavalid=0, slv_address unchanged.
